// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the next-PC generator: FSM states, BTB entry
// layout and redirect priority selection.
package pc_gen_pkg;

   localparam logic [63:0] DEFAULT_RESET_VECTOR = 64'h6000_0000;
   localparam int          BTB_MAX_W            = 64;
   localparam int          MAX_REDIRECT         = 32;

   typedef enum logic {BOOT, RUN} pc_state_e;

   // Fields are sized for the widest supported XLEN; narrower cores zero-extend.
   typedef struct packed {
      logic                 valid;
      logic [BTB_MAX_W-1:0] tag;
      logic [BTB_MAX_W-1:0] target;
   } btb_entry_t;

   function automatic logic [4:0] prio_sel(input logic [MAX_REDIRECT-1:0] req);
      logic [4:0] sel;
      sel = '0;
      for (int i = MAX_REDIRECT - 1; i >= 0; i--) begin
         if (req[i]) sel = 5'(i);
      end
      return sel;
   endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch handshake, redirect channels and BTB maintenance bus of the PC generator.
interface pc_gen_if #(
   parameter int XLEN         = 64,
   parameter int NUM_REDIRECT = 2
);
   logic [NUM_REDIRECT-1:0]      redirect_valid;
   logic [NUM_REDIRECT*XLEN-1:0] redirect_pc;
   logic                         fetch_valid;
   logic                         fetch_ready;
   logic [XLEN-1:0]              fetch_pc;
   logic                         fetch_pred_taken;
   logic                         btb_upd_valid;
   logic [XLEN-1:0]              btb_upd_pc;
   logic [XLEN-1:0]              btb_upd_target;
   logic                         btb_upd_taken;
   logic                         btb_flush;

   modport master (
      input  redirect_valid, redirect_pc, fetch_ready,
      input  btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken, btb_flush,
      output fetch_valid, fetch_pc, fetch_pred_taken
   );

   modport slave (
      output redirect_valid, redirect_pc, fetch_ready,
      output btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken, btb_flush,
      input  fetch_valid, fetch_pc, fetch_pred_taken
   );
endinterface

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer with full tags; combinational lookup,
// edge-triggered install/invalidate and whole-table flush.
module pc_btb import pc_gen_pkg::*; #(
   parameter int XLEN        = 64,
   parameter int BTB_ENTRIES = 8,
   parameter int FETCH_BYTES = 4
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic [XLEN-1:0] lk_pc,
   output logic            hit,
   output logic [XLEN-1:0] target,
   input  logic            upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic [XLEN-1:0] upd_target,
   input  logic            upd_taken,
   input  logic            flush
);
   localparam int IDX   = $clog2(BTB_ENTRIES);
   localparam int OFF   = $clog2(FETCH_BYTES);
   localparam int TAG_W = XLEN - IDX - OFF;

   btb_entry_t       entry [BTB_ENTRIES];
   btb_entry_t       lk_ent;
   btb_entry_t       upd_ent;
   logic [IDX-1:0]   lk_idx;
   logic [IDX-1:0]   upd_idx;
   logic [TAG_W-1:0] lk_tag;
   logic [TAG_W-1:0] upd_tag;

   assign lk_idx  = lk_pc[IDX+OFF-1:OFF];
   assign lk_tag  = lk_pc[XLEN-1:IDX+OFF];
   assign upd_idx = upd_pc[IDX+OFF-1:OFF];
   assign upd_tag = upd_pc[XLEN-1:IDX+OFF];

   // Byte offset within a fetch slot never takes part in indexing or tagging.
   if (OFF > 0) begin : g_low
      logic unused_low;
      assign unused_low = ^{lk_pc[OFF-1:0], upd_pc[OFF-1:0]};
   end

   assign lk_ent  = entry[lk_idx];
   assign upd_ent = entry[upd_idx];
   assign hit     = lk_ent.valid && (lk_ent.tag == BTB_MAX_W'(lk_tag));
   assign target  = lk_ent.target[XLEN-1:0];

   // Flush outranks any concurrent update so the entry is left invalid.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < BTB_ENTRIES; i++) entry[i] <= '0;
      end else if (flush) begin
         for (int i = 0; i < BTB_ENTRIES; i++) entry[i].valid <= 1'b0;
      end else if (upd_valid) begin
         if (upd_taken) begin
            entry[upd_idx].valid  <= 1'b1;
            entry[upd_idx].tag    <= BTB_MAX_W'(upd_tag);
            entry[upd_idx].target <= BTB_MAX_W'(upd_target);
         end else if (upd_ent.tag == BTB_MAX_W'(upd_tag)) begin
            entry[upd_idx].valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/pc_gen_unit.sv
// Next-PC generator: boot FSM, fetch PC register, prioritised redirect mux and
// BTB-driven predicted-taken steering.
module pc_gen_unit import pc_gen_pkg::*; #(
   parameter int              XLEN         = 64,
   parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR[XLEN-1:0],
   parameter int              NUM_REDIRECT = 2,
   parameter int              FETCH_BYTES  = 4,
   parameter int              BTB_ENTRIES  = 8
) (
   input  logic      clock,
   input  logic      reset_n,
   pc_gen_if.master  bus
);
   localparam int SELW = (NUM_REDIRECT > 1) ? $clog2(NUM_REDIRECT) : 1;

   pc_state_e       state_q;
   pc_state_e       state_n;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_n;
   logic            redirect_any;
   logic [SELW-1:0] sel;
   logic [XLEN-1:0] redir_tgt [NUM_REDIRECT];
   logic            offer;
   logic            btb_hit;
   logic [XLEN-1:0] btb_tgt;

   for (genvar g = 0; g < NUM_REDIRECT; g++) begin : g_redir
      assign redir_tgt[g] = bus.redirect_pc[g*XLEN +: XLEN];
   end

   assign redirect_any = |bus.redirect_valid;
   assign sel          = SELW'(prio_sel(MAX_REDIRECT'(bus.redirect_valid)));

   pc_btb #(
      .XLEN        (XLEN),
      .BTB_ENTRIES (BTB_ENTRIES),
      .FETCH_BYTES (FETCH_BYTES)
   ) u_btb (
      .clock      (clock),
      .reset_n    (reset_n),
      .lk_pc      (pc_q),
      .hit        (btb_hit),
      .target     (btb_tgt),
      .upd_valid  (bus.btb_upd_valid),
      .upd_pc     (bus.btb_upd_pc),
      .upd_target (bus.btb_upd_target),
      .upd_taken  (bus.btb_upd_taken),
      .flush      (bus.btb_flush)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= BOOT;
      else          state_q <= state_n;
   end

   always_comb begin
      state_n = state_q;
      case (state_q)
         BOOT:    state_n = RUN;
         RUN:     state_n = RUN;
         default: state_n = BOOT;
      endcase
   end

   // A redirect squashes the offer in the cycle it arrives.
   always_comb begin
      offer                = (state_q == RUN) && !redirect_any;
      bus.fetch_valid      = offer;
      bus.fetch_pred_taken = offer && btb_hit;
      bus.fetch_pc         = pc_q;
   end

   always_comb begin
      pc_n = pc_q;
      if (redirect_any)
         pc_n = redir_tgt[sel];
      else if (offer && bus.fetch_ready)
         pc_n = btb_hit ? btb_tgt : pc_q + XLEN'(FETCH_BYTES);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) pc_q <= RESET_VECTOR;
      else          pc_q <= pc_n;
   end

endmodule

// File: tb/tb_pc_gen_unit.sv
// Scoreboard bench for pc_gen_unit: directed cycle vectors push expected offers,
// a negedge monitor pops and compares whenever fetch_valid is presented.
module tb_pc_gen_unit;
   localparam int XLEN = 64;
   localparam int NR   = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pc_gen_if #(.XLEN(XLEN), .NUM_REDIRECT(NR)) bus ();

   pc_gen_unit #(
      .XLEN         (XLEN),
      .RESET_VECTOR (64'h6000_0000),
      .NUM_REDIRECT (NR),
      .FETCH_BYTES  (4),
      .BTB_ENTRIES  (8)
   ) dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   typedef struct {
      logic [63:0] pc;
      logic        pred;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   exp_t push_e;
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.fetch_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_offer actual=%h required=no_offer", bus.fetch_pc);
         end else begin
            mon_e = sb.pop_front();
            chk("fetch_pc", bus.fetch_pc, mon_e.pc);
            chk("pred_taken", 64'(bus.fetch_pred_taken), 64'(mon_e.pred));
         end
      end
   end

   // Called at posedge+1; drives one cycle and records the expected offer.
   task automatic step(input logic [1:0] rv, input logic [63:0] r0, input logic [63:0] r1,
                       input logic rdy, input logic ev, input logic [63:0] epc, input logic ep);
      bus.redirect_valid = rv;
      bus.redirect_pc    = {r1, r0};
      bus.fetch_ready    = rdy;
      if (ev) begin
         push_e.pc   = epc;
         push_e.pred = ep;
         sb.push_back(push_e);
      end
      @(posedge clk);
      #1;
      bus.btb_upd_valid = 1'b0;
      bus.btb_upd_taken = 1'b0;
      bus.btb_flush     = 1'b0;
   endtask

   task automatic offer(input logic [63:0] pc, input logic p, input logic rdy = 1'b1);
      step(2'b00, 64'd0, 64'd0, rdy, 1'b1, pc, p);
   endtask

   task automatic redir(input logic [1:0] rv, input logic [63:0] r0, input logic [63:0] r1 = 64'd0);
      step(rv, r0, r1, 1'b1, 1'b0, 64'd0, 1'b0);
   endtask

   task automatic btb(input logic [63:0] pc, input logic [63:0] tgt, input logic tk, input logic fl);
      bus.btb_upd_valid  = 1'b1;
      bus.btb_upd_pc     = pc;
      bus.btb_upd_target = tgt;
      bus.btb_upd_taken  = tk;
      bus.btb_flush      = fl;
   endtask

   task automatic flush_only();
      bus.btb_flush = 1'b1;
   endtask

   // Assert reset between edges, check outputs drop at once, release at posedge+1.
   task automatic reset_mid(input logic was_running);
      if (was_running) chk("pre_reset_valid", 64'(bus.fetch_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("reset_valid", 64'(bus.fetch_valid), 64'd0);
      chk("reset_pred", 64'(bus.fetch_pred_taken), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      bus.redirect_valid = '0;
      bus.redirect_pc    = '0;
      bus.fetch_ready    = 1'b1;
      bus.btb_upd_valid  = 1'b0;
      bus.btb_upd_pc     = '0;
      bus.btb_upd_target = '0;
      bus.btb_upd_taken  = 1'b0;
      bus.btb_flush      = 1'b0;
      @(posedge clk);
      #1;
      reset_mid(1'b0);

      // Boot and sequential fetch, then a three-cycle stall.
      step(2'b00, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0);
      offer(64'h6000_0000, 1'b0);
      offer(64'h6000_0004, 1'b0);
      offer(64'h6000_0008, 1'b0, 1'b0);
      offer(64'h6000_0008, 1'b0, 1'b0);
      offer(64'h6000_0008, 1'b0, 1'b0);
      offer(64'h6000_0008, 1'b0);
      offer(64'h6000_000C, 1'b0);

      // Redirect priority.
      redir(2'b11, 64'h8000_0000, 64'h9000_0000);
      offer(64'h8000_0000, 1'b0);
      redir(2'b10, 64'h8000_0000, 64'h9000_0000);
      offer(64'h9000_0000, 1'b0);
      offer(64'h9000_0004, 1'b0);

      // Install and predicted-taken steering.
      btb(64'h6000_0010, 64'h6000_0100, 1'b1, 1'b0);
      redir(2'b01, 64'h6000_0008);
      offer(64'h6000_0008, 1'b0);
      offer(64'h6000_000C, 1'b0);
      offer(64'h6000_0010, 1'b1);
      offer(64'h6000_0100, 1'b0);
      offer(64'h6000_0104, 1'b0);

      // Invalidate via not-taken update.
      btb(64'h6000_0010, 64'd0, 1'b0, 1'b0);
      redir(2'b01, 64'h6000_0010);
      offer(64'h6000_0010, 1'b0);
      offer(64'h6000_0014, 1'b0);

      // Flush in the hit cycle: prediction still used, gone afterwards.
      btb(64'h6000_0010, 64'h6000_0100, 1'b1, 1'b0);
      redir(2'b01, 64'h6000_000C);
      offer(64'h6000_000C, 1'b0);
      flush_only();
      offer(64'h6000_0010, 1'b1);
      offer(64'h6000_0100, 1'b0);
      redir(2'b01, 64'h6000_0010);
      offer(64'h6000_0010, 1'b0);
      offer(64'h6000_0014, 1'b0);

      // Flush beats a same-cycle install.
      btb(64'h6000_0010, 64'h6000_0100, 1'b1, 1'b1);
      redir(2'b01, 64'h6000_0010);
      offer(64'h6000_0010, 1'b0);
      offer(64'h6000_0014, 1'b0);

      // Aliasing index with a different tag.
      btb(64'h6000_0010, 64'h6000_0100, 1'b1, 1'b0);
      redir(2'b01, 64'h6000_0030);
      offer(64'h6000_0030, 1'b0);
      offer(64'h6000_0034, 1'b0);
      redir(2'b01, 64'h6000_0010);
      btb(64'h6000_0010, 64'd0, 1'b0, 1'b0);
      offer(64'h6000_0010, 1'b1);
      offer(64'h6000_0100, 1'b0);
      redir(2'b01, 64'h6000_0010);
      offer(64'h6000_0010, 1'b0);
      offer(64'h6000_0014, 1'b0);

      // Wrap past the top of the address space.
      redir(2'b01, 64'hFFFF_FFFF_FFFF_FFFC);
      offer(64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
      offer(64'h0000_0000_0000_0000, 1'b0);
      btb(64'h6000_0000, 64'h6000_0200, 1'b1, 1'b0);
      offer(64'h0000_0000_0000_0004, 1'b0);

      // Asynchronous reset mid-stream clears the BTB entry just installed.
      reset_mid(1'b1);
      step(2'b00, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0);
      offer(64'h6000_0000, 1'b0);
      offer(64'h6000_0004, 1'b0);

      // Redirect taken while still in BOOT.
      reset_mid(1'b1);
      redir(2'b10, 64'd0, 64'h7000_0000);
      offer(64'h7000_0000, 1'b0);
      offer(64'h7000_0004, 1'b0);

      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
Parametrised next-PC generator at the front of the core pipeline. Holds the architectural fetch PC and boots it to a configurable reset vector. Offers the PC to instruction fetch through a valid/ready handshake and arbitrates several prioritised redirect sources (e.g. trap/MEM, EX branch). Includes a small direct-mapped branch target buffer (BTB) so that predicted-taken fetches redirect without a bubble.

Parameters:
XLEN, 64, PC width in bits
RESET_VECTOR, 64'h60000000, first fetch address after reset
NUM_REDIRECT, 2, number of redirect channels; index 0 has highest priority
FETCH_BYTES, 4, sequential increment; power of two
BTB_ENTRIES, 8, BTB depth; power of two, minimum 2

Ports:
clock  in  1  single clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
redirect_valid  in  NUM_REDIRECT  per-channel redirect request
redirect_pc  in  NUM_REDIRECT*XLEN  channel i target in bits [i*XLEN +: XLEN]
fetch_valid  out  1  fetch_pc is offered to IF
fetch_ready  in  1  IF accepts fetch_pc this cycle
fetch_pc  out  XLEN  current fetch address
fetch_pred_taken  out  1  BTB hit on fetch_pc; the next PC is the BTB target
btb_upd_valid  in  1  BTB update strobe from branch resolution
btb_upd_pc  in  XLEN  branch address
btb_upd_target  in  XLEN  resolved target
btb_upd_taken  in  1  1 = install/overwrite entry, 0 = invalidate matching entry
btb_flush  in  1  invalidate all BTB entries

Behaviour:
- Reset (reset_n=0, asynchronous): state=BOOT, pc=RESET_VECTOR, all BTB valid bits=0, fetch_valid=0, fetch_pred_taken=0. Reset mid-operation discards all state immediately.
- FSM states:
  - BOOT: the first clock edge after release; fetch_valid=0. Next state is RUN.
  - RUN: PC is offered.
  - No return to BOOT except via reset.
- fetch_valid = (state==RUN) && !(|redirect_valid). A redirect squashes the current offer in the same cycle.
- Next-PC priority, evaluated every edge:
  1. Any redirect_valid: pc <= redirect_pc of the lowest-index asserted channel. Applies in BOOT and RUN. fetch_ready is ignored.
  2. Otherwise, in RUN with fetch_valid && fetch_ready: pc <= BTB hit ? BTB target : pc + FETCH_BYTES.
  3. Otherwise: pc holds. This covers stall and BOOT without redirect.
- Redirect latency: the redirect target appears on fetch_pc with fetch_valid=1 on the cycle after the request, if no new redirect arrives.
- Arithmetic: pc + FETCH_BYTES is computed modulo 2^XLEN; all-ones minus 3 wraps to 0. Redirect and BTB targets pass through unmodified, with no alignment masking.
- BTB organisation:
  - IDX = log2(BTB_ENTRIES), OFF = log2(FETCH_BYTES).
  - index = pc[IDX+OFF-1:OFF]; tag = pc[XLEN-1:IDX+OFF] (full tag).
  - Lookup is combinational on fetch_pc; hit = valid && tag match.
  - fetch_pred_taken = hit && fetch_valid.
- BTB update, on the edge:
  - btb_upd_taken=1: write {valid=1, tag, target} at the index of btb_upd_pc.
  - btb_upd_taken=0: clear valid only if the stored tag matches.
- BTB simultaneous events:
  - Lookup and update of the same entry in one cycle: lookup sees the old contents.
  - btb_flush and btb_upd_valid in one cycle: the flush wins and the entry ends invalid.
  - A flush takes effect from the next cycle.
- Outputs are combinational from registered state plus redirect_valid. There is no combinational path from fetch_ready to any output.

Decomposition:
- Package pc_gen_pkg:
  - default RESET_VECTOR constant
  - pc_state_e {BOOT, RUN}
  - parametrised btb_entry_t struct {valid, tag, target}
  - function prio_sel returning the lowest set index of a redirect vector
- Sub-module pc_btb: storage, lookup, update and flush.
- pc_gen_unit holds the FSM, pc register and next-PC mux.

Test Plan:
- Reset release, fetch_ready=1, no redirects -> cycle 1 fetch_valid=0; cycle 2 fetch_pc=0x60000000; then 0x60000004, 0x60000008 on consecutive cycles.
- Hold fetch_ready=0 for 3 cycles at pc 0x60000008 -> fetch_pc stays 0x60000008 and fetch_valid stays 1; resumes at 0x6000000C after ready returns.
- Same cycle redirect_valid=2'b11, ch0=0x80000000, ch1=0x90000000 -> fetch_valid=0 that cycle; next cycle fetch_pc=0x80000000. ch1 alone -> 0x90000000.
- BTB install:
  - Stimulus: btb_upd pc=0x60000010, target=0x60000100, taken=1; then sequential fetch reaches 0x60000010.
  - Response: fetch_pred_taken=1 at 0x60000010; next fetch_pc=0x60000100.
  - Stimulus: update with taken=0, or btb_flush.
  - Response: sequential 0x60000014 follows instead.
- Aliasing: install 0x60000010, then fetch 0x60000030 (same index, different tag) -> no hit. Redirect to 0xFFFFFFFFFFFFFFFC, accept -> next fetch_pc=0.
- Assert reset_n=0 mid-stream, asynchronously between edges -> fetch_valid drops immediately and the BTB is empty. After release, the BOOT sequence repeats from 0x60000000.
